// File: rtl/axil_led_pkg.sv
// Shared register offsets, response codes and channel state for the AXI-Lite LED/PWM block.
package axil_led_pkg;

  localparam int ADDR_DATA      = 'h00;
  localparam int ADDR_MODE      = 'h04;
  localparam int ADDR_PRESCALE  = 'h08;
  localparam int ADDR_STATUS    = 'h0C;
  localparam int ADDR_DUTY_BASE = 'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // CH_OFF holds every READY low for the first cycle out of reset.
  typedef enum logic [1:0] {
    CH_OFF,
    CH_IDLE,
    CH_RESP
  } ch_state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/led_pwm_core.sv
// Shared prescaler and PWM counter with one registered compare/select per LED.
module led_pwm_core
  import axil_led_pkg::*;
#(
  parameter int NUM_LEDS      = 4,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic                         restart_i,
  input  logic [NUM_LEDS-1:0]          data_i,
  input  logic [NUM_LEDS-1:0]          mode_i,
  input  logic [NUM_LEDS*PWM_BITS-1:0] duty_i,
  input  logic [PRESCALE_BITS-1:0]     prescale_i,
  output logic [NUM_LEDS-1:0]          led_o,
  output logic [PWM_BITS-1:0]          pwm_cnt_o,
  output logic                         wrap_o
);

  logic [PRESCALE_BITS-1:0] pre_cnt_q;
  logic [PWM_BITS-1:0]      pwm_cnt_q;
  logic [NUM_LEDS-1:0]      led_q;
  logic [NUM_LEDS-1:0]      led_d;
  logic                     tick;

  // >= rather than == keeps the prescaler bounded even if the limit ever drops below the count.
  assign tick   = pre_cnt_q >= prescale_i;
  assign wrap_o = tick && (pwm_cnt_q == '1) && !restart_i;

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
    assign led_d[gi] = mode_i[gi] ? (pwm_cnt_q < duty_i[gi*PWM_BITS +: PWM_BITS]) : data_i[gi];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      led_q <= led_d;
      if (restart_i) begin
        pre_cnt_q <= '0;
        pwm_cnt_q <= '0;
      end else if (tick) begin
        pre_cnt_q <= '0;
        pwm_cnt_q <= pwm_cnt_q + 1'b1;
      end else begin
        pre_cnt_q <= pre_cnt_q + 1'b1;
      end
    end
  end

  assign led_o     = led_q;
  assign pwm_cnt_o = pwm_cnt_q;

endmodule

// File: rtl/axil_led_pwm_gpio.sv
// AXI4-Lite slave driving NUM_LEDS static/PWM LEDs. Define AXIL_LED_PWM_IRQ_EN to enable
// the period-wrap interrupt (STATUS bit 31, write-1-clear) on irq_o.
module axil_led_pwm_gpio
  import axil_led_pkg::*;
#(
  parameter int NUM_LEDS      = 4,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16,
  parameter int ADDR_W        = 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [31:0]         S_AXI_WDATA,
  input  logic [3:0]          S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [31:0]         S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  output logic [NUM_LEDS-1:0] led_o,
  output logic                irq_o
);

  localparam int NUM_REGS = ADDR_DUTY_BASE / 4 + NUM_LEDS;

  ch_state_e                wr_state_q, rd_state_q;
  logic                     aw_full_q, w_full_q;
  logic [ADDR_W-1:0]        aw_addr_q;
  logic [31:0]              w_data_q;
  logic [3:0]               w_strb_q;
  logic [1:0]               bresp_q, rresp_q;
  logic [31:0]              rdata_q;
  logic [NUM_LEDS-1:0]      data_q, mode_q;
  logic [PRESCALE_BITS-1:0] prescale_q;
  logic [PWM_BITS-1:0]      duty_q [NUM_LEDS];

  logic [NUM_LEDS*PWM_BITS-1:0] duty_flat;
  logic [PWM_BITS-1:0]          pwm_cnt;
  logic                         pwm_wrap;
  logic                         irq_pend;
  logic [31:0]                  regs_view [NUM_REGS];

  logic [31:0] wr_idx, wr_old, wr_data_d, rd_idx, rd_val;
  logic        wr_hit, wr_err, wr_commit, wr_en, rd_hit, prescale_wr;

  assign regs_view[ADDR_DATA/4]     = 32'(data_q);
  assign regs_view[ADDR_MODE/4]     = 32'(mode_q);
  assign regs_view[ADDR_PRESCALE/4] = 32'(prescale_q);
  assign regs_view[ADDR_STATUS/4]   = {irq_pend, 31'(pwm_cnt)};

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_duty
    assign regs_view[ADDR_DUTY_BASE/4 + gi]  = 32'(duty_q[gi]);
    assign duty_flat[gi*PWM_BITS +: PWM_BITS] = duty_q[gi];
  end

  always_comb begin
    wr_idx = 32'(aw_addr_q) >> 2;
    wr_old = '0;
    wr_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == 32'(i)) begin
        wr_old = regs_view[i];
        wr_hit = 1'b1;
      end
    end
    wr_data_d = strb_merge(wr_old, w_data_q, w_strb_q);
`ifdef AXIL_LED_PWM_IRQ_EN
    wr_err = !wr_hit;
`else
    wr_err = !wr_hit || (wr_idx == 32'(ADDR_STATUS / 4));
`endif
    wr_commit   = aw_full_q && w_full_q;
    wr_en       = wr_commit && !wr_err;
    prescale_wr = wr_en && (wr_idx == 32'(ADDR_PRESCALE / 4));
  end

  always_comb begin
    rd_idx = 32'(S_AXI_ARADDR) >> 2;
    rd_val = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == 32'(i)) begin
        rd_val = regs_view[i];
        rd_hit = 1'b1;
      end
    end
  end

  // Holding registers fill independently; the register file commits once both are full.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= CH_OFF;
      rd_state_q <= CH_OFF;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      data_q     <= '0;
      mode_q     <= '0;
      prescale_q <= '0;
      for (int i = 0; i < NUM_LEDS; i++) duty_q[i] <= '0;
    end else begin
      case (wr_state_q)
        CH_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            aw_full_q <= 1'b1;
            aw_addr_q <= S_AXI_AWADDR;
          end
          if (S_AXI_WVALID && S_AXI_WREADY) begin
            w_full_q <= 1'b1;
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
          end
          if (wr_commit) begin
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            bresp_q    <= wr_err ? RESP_SLVERR : RESP_OKAY;
            wr_state_q <= CH_RESP;
          end
        end
        CH_RESP: if (S_AXI_BREADY) wr_state_q <= CH_IDLE;
        default: wr_state_q <= CH_IDLE;
      endcase

      if (wr_en) begin
        if (wr_idx == 32'(ADDR_DATA / 4))     data_q     <= wr_data_d[NUM_LEDS-1:0];
        if (wr_idx == 32'(ADDR_MODE / 4))     mode_q     <= wr_data_d[NUM_LEDS-1:0];
        if (wr_idx == 32'(ADDR_PRESCALE / 4)) prescale_q <= wr_data_d[PRESCALE_BITS-1:0];
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (wr_idx == 32'(ADDR_DUTY_BASE / 4 + i)) duty_q[i] <= wr_data_d[PWM_BITS-1:0];
        end
      end

      case (rd_state_q)
        CH_IDLE: begin
          if (S_AXI_ARVALID) begin
            rdata_q    <= rd_val;
            rresp_q    <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            rd_state_q <= CH_RESP;
          end
        end
        CH_RESP: if (S_AXI_RREADY) rd_state_q <= CH_IDLE;
        default: rd_state_q <= CH_IDLE;
      endcase
    end
  end

`ifdef AXIL_LED_PWM_IRQ_EN
  logic irq_pend_q;
  logic status_clr;

  assign status_clr = wr_en && (wr_idx == 32'(ADDR_STATUS / 4)) && wr_data_d[31];

  // Write-1-clear deliberately beats a wrap landing in the same cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET)          irq_pend_q <= 1'b0;
    else if (status_clr) irq_pend_q <= 1'b0;
    else if (pwm_wrap)   irq_pend_q <= 1'b1;
  end

  assign irq_pend = irq_pend_q;
`else
  logic unused_wrap;
  assign unused_wrap = pwm_wrap;
  assign irq_pend    = 1'b0;
`endif

  led_pwm_core #(
    .NUM_LEDS     (NUM_LEDS),
    .PWM_BITS     (PWM_BITS),
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_core (
    .clk_i     (ACLK),
    .srst_i    (ARESET),
    .restart_i (prescale_wr),
    .data_i    (data_q),
    .mode_i    (mode_q),
    .duty_i    (duty_flat),
    .prescale_i(prescale_q),
    .led_o     (led_o),
    .pwm_cnt_o (pwm_cnt),
    .wrap_o    (pwm_wrap)
  );

  assign S_AXI_AWREADY = (wr_state_q == CH_IDLE) && !aw_full_q;
  assign S_AXI_WREADY  = (wr_state_q == CH_IDLE) && !w_full_q;
  assign S_AXI_BVALID  = (wr_state_q == CH_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = (rd_state_q == CH_IDLE);
  assign S_AXI_RVALID  = (rd_state_q == CH_RESP);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign irq_o         = irq_pend;

endmodule

// File: doc/axil_led_pwm_gpio.md
Name: axil_led_pwm_gpio

Overview:
- Parametrised AXI4-Lite slave that drives NUM_LEDS board LEDs from the PS GP master port.
- Replaces the fixed 4-bit GPIO LED output.
- Each LED is individually either a static bit or a PWM channel; all PWM channels share one prescaler and one PWM counter.
- Sits on the PL side behind the GP0 interconnect at 0xA000_0000.

Parameters:
- NUM_LEDS, 4: LED channel count, 1..32.
- PWM_BITS, 8: PWM counter and duty width, 2..16.
- PRESCALE_BITS, 16: prescaler register and counter width.
- ADDR_W, 8: AXI-Lite address width; must cover 0x10+4*(NUM_LEDS-1).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- S_AXI_AWADDR  in  ADDR_W  write address.
- S_AXI_AWVALID in 1; S_AXI_AWREADY out 1: write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID in 1; S_AXI_WREADY out 1: write data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID out 1; S_AXI_BREADY in 1: write response handshake.
- S_AXI_ARADDR  in  ADDR_W  read address.
- S_AXI_ARVALID in 1; S_AXI_ARREADY out 1: read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID out 1; S_AXI_RREADY in 1: read data handshake.
- led_o  out  NUM_LEDS  LED drive, registered.
- irq_o  out  1  period-wrap interrupt (see Optional Feature).

Behaviour:
- Clocking and reset: one clock, ACLK. ARESET is synchronous and active-high. ARESET takes priority over everything and aborts any in-flight transaction without issuing a response.
- Reset values: all registers 0; led_o=0; irq_o=0; all READY/VALID outputs 0; BRESP=RRESP=0; RDATA=0.
- Register map (byte addresses, word-aligned; ADDR[1:0] ignored):
  - 0x00 DATA: RW, bits [NUM_LEDS-1:0]; static LED values.
  - 0x04 MODE: RW, bit i = 1 selects PWM for LED i.
  - 0x08 PRESCALE: RW, [PRESCALE_BITS-1:0].
  - 0x0C STATUS: RO, [PWM_BITS-1:0] = live PWM counter; bit 31 = irq pending.
  - 0x10+4*i DUTY[i]: RW, [PWM_BITS-1:0].
  - Unused bits read 0.
- Write channel:
  - AW and W are accepted independently, one cycle each, into holding registers. READY stays low while that channel's holding register is full.
  - In the cycle both are held, the register is updated per WSTRB byte lanes and BVALID rises the next cycle.
  - No new AW/W is accepted until the B handshake completes; one write outstanding.
- Read channel:
  - ARREADY is high when no read is pending.
  - RVALID rises one cycle after the AR handshake and holds RDATA/RRESP stable until RREADY.
- Unmapped addresses (including DUTY index >= NUM_LEDS) and writes to STATUS return SLVERR (2'b10). Such writes change nothing; such reads return 0.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- Prescaler:
  - pre_cnt counts 0..PRESCALE, then wraps to 0 and asserts tick for one cycle.
  - PRESCALE=0 gives a tick every cycle.
- PWM counter:
  - pwm_cnt increments on tick and wraps 2^PWM_BITS-1 -> 0.
  - Any write to PRESCALE clears pre_cnt and pwm_cnt in the same cycle the register updates.
- Output:
  - led_o[i] <= MODE[i] ? (pwm_cnt < DUTY[i]) : DATA[i].
  - Registered: one cycle after a DATA/MODE/DUTY write commits.
  - DUTY=0 is always off; DUTY=max gives (2^PWM_BITS-1)/2^PWM_BITS on-time.
- A mode switch takes effect at the next cycle, not at a period boundary.

Optional Feature:
- Macro: AXIL_LED_PWM_IRQ_EN.
- Defined:
  - The pending bit sets when pwm_cnt wraps to 0.
  - Writing 1 to STATUS bit 31 clears it; this write returns OKAY, not SLVERR, and the write-1-clear wins over a same-cycle set.
  - irq_o equals the pending bit, registered.
- Undefined:
  - irq_o tied 0 and STATUS bit 31 reads 0.
  - Writes to STATUS return SLVERR.

Decomposition:
- Package axil_led_pkg holds:
  - register offset localparams (ADDR_DATA, ADDR_MODE, ADDR_PRESCALE, ADDR_STATUS, ADDR_DUTY_BASE);
  - RESP_OKAY/RESP_SLVERR constants;
  - the read/write channel state enum.
- One sub-module, led_pwm_core: prescaler, pwm_cnt, per-LED compare and output register. The top module keeps the AXI-Lite slave and the register file.

Test Plan:
- Reset: after 5 cycles of ARESET=1, all outputs are 0. Read 0x00 returns 0 with RRESP OKAY.
- Static: write 0x00=0xFFFFFFFF, WSTRB=0xF, NUM_LEDS=4 -> led_o=4'hF two cycles after the write commits; reading 0x00 returns 0x0000000F.
- PWM: PRESCALE=0, MODE=0x1, DUTY[0]=64, PWM_BITS=8 -> led_o[0] high for exactly 64 of every 256 cycles. DUTY=0 -> never high.
- Handshake: W presented 3 cycles before AW, BREADY held low 4 cycles -> one B response, BVALID stable, no second write accepted meanwhile.
- Errors: write 0x40 with NUM_LEDS=4 -> BRESP=2'b10 and no register change; read 0x40 -> RDATA=0, RRESP=2'b10.
- IRQ (macro defined): PRESCALE=1 -> irq_o rises 512 cycles after the PRESCALE write; write STATUS=0x80000000 clears it.
